mips_run_ctrl: RTL and testbench
================================

// Module: mips_run_ctrl
// PURPOSE
//   Bench-side run controller for the pipelined MIPS CPU: sequences CPU reset, counts run
//   and retired-writeback cycles, detects program halt or timeout, and raises done so the
//   testbench can $finish. Sits between the bench clock/reset and the mips core; observes
//   the core's fetch PC and GRF writeback port.
// PARAMETERS
//   RESET_CYCLES  2             cycles cpu_reset is held after reset drops (>=1)
//   PC_W          32            PC width
//   CNT_W         32            cycle_cnt / retire_cnt width
//   END_PC        32'h0000_7000 halt when fetch PC >= this value (ran off the end of IM)
//   HALT_REPEAT   4             halt after this many consecutive non-stall cycles with unchanged pc_f (>=1)
//   TIMEOUT       100000        RUN-cycle limit; 0 disables the timeout
// PORTS
//   clk         in   1      bench clock
//   reset       in   1      synchronous, active-high
//   cpu_reset   out  1      reset into the mips core
//   pc_f        in   PC_W   core fetch-stage PC
//   stall       in   1      core F/D stall; freezes stuck-PC detection
//   wb_en       in   1      GRF write enable at writeback
//   wb_pc       in   32     PC of the writing instruction
//   wb_addr     in   5      GRF destination register
//   wb_data     in   32     GRF write data
//   state       out  2      0=HOLD 1=RUN 2=DONE
//   cycle_cnt   out  CNT_W  completed RUN cycles
//   retire_cnt  out  CNT_W  wb_en events in RUN
//   halted      out  1      sticky: halt detected
//   timed_out   out  1      sticky: TIMEOUT reached without a halt
//   done        out  1      (state==DONE)
// BEHAVIOUR
//   - One clock domain; reset is synchronous, active-high. All outputs are registered.
//   - Reset values: state=HOLD, cpu_reset=1, cycle_cnt=0, retire_cnt=0, halted=0, timed_out=0,
//     done=0. Internal registers: hold_cnt=0, prev_pc=0, same_cnt=0.
//   - Reset asserted in any state, including mid-RUN or DONE, returns the block to reset values
//     on that edge.
//   - HOLD: cpu_reset=1. hold_cnt increments each cycle. On the edge where hold_cnt==RESET_CYCLES-1,
//     go to RUN. cpu_reset is therefore high for exactly RESET_CYCLES cycles after reset drops.
//   - RUN: cpu_reset=0. Every edge does the following:
//       cycle_cnt += 1, saturating at all-ones;
//       retire_cnt += wb_en, saturating at all-ones; wb_addr==0 still counts;
//       prev_pc <= pc_f.
//     Stuck-PC detection, evaluated only when stall==0:
//       pc_f==prev_pc: same_cnt += 1;
//       pc_f!=prev_pc: same_cnt = 0.
//     When stall==1, same_cnt holds.
//   - Halt conditions, evaluated in RUN:
//       (a) pc_f >= END_PC (unsigned compare);
//       (b) stall==0 && pc_f==prev_pc && same_cnt==HALT_REPEAT-1.
//     Either condition: next state DONE with halted=1.
//   - Timeout: TIMEOUT!=0, cycle_cnt==TIMEOUT-1 in RUN, and no halt condition -> next state DONE
//     with timed_out=1. cycle_cnt ends at TIMEOUT.
//   - Halt and timeout on the same edge: halted=1, timed_out=0 (halt wins).
//   - DONE: sticky until reset. Counters, flags and prev_pc freeze. cpu_reset stays 0 and the core
//     is not stopped. done=1. Exactly one of halted/timed_out is 1.
//   - Latency: done/halted/timed_out assert the cycle after the detecting edge.
// CONFIGURATION
//   RUN_CTRL_TRACE_EN defined:
//     - On each RUN edge with wb_en && wb_addr!=0, print
//       $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data).
//     - Print one summary line on entering DONE: cycle_cnt, retire_cnt, and the reason.
//   RUN_CTRL_TRACE_EN undefined:
//     - No display statements are compiled. wb_pc/wb_data are unused.
//     - retire_cnt and all other behaviour are identical.
// TESTING
//   1 RESET_CYCLES=3; reset high 2 cycles then low -> cpu_reset=1 for exactly 3 cycles, state=RUN
//     on the 4th cycle, cycle_cnt=0 at RUN entry.
//   2 pc_f steps 0x3000,0x3004,... and reaches 0x7000 -> next cycle state=DONE, halted=1,
//     timed_out=0; counters freeze.
//   3 pc_f held at 0x3010 with stall=0, HALT_REPEAT=4 -> halted on the 4th repeated cycle.
//     Inserting stall=1 cycles delays the halt by the same number of cycles.
//   4 TIMEOUT=50, pc_f incrementing below END_PC -> DONE after 50 RUN cycles, timed_out=1,
//     cycle_cnt=50. With END_PC hit on cycle 50 instead -> halted=1, timed_out=0.
//   5 reset pulsed mid-RUN at cycle_cnt=20 -> all outputs return to reset values on that edge;
//     HOLD runs RESET_CYCLES cycles again.
//   6 wb_en pulses 7 times (2 with wb_addr=0) -> retire_cnt=7. With RUN_CTRL_TRACE_EN defined,
//     exactly 5 trace lines, e.g. "@00003000: $ 1 <= 00000005".

Source files
------------

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: bench-side run controller for the pipelined MIPS core.
// Holds the core in reset for RESET_CYCLES cycles, then counts run cycles and
// retired writebacks until the program halts (PC past END_PC, or PC stuck for
// HALT_REPEAT non-stall cycles) or the TIMEOUT cycle limit is reached.
// Optional feature macro: RUN_CTRL_TRACE_EN (prints a writeback trace and a
// final verdict line; the default build compiles no display statements).
module mips_run_ctrl #(
    parameter int unsigned     RESET_CYCLES = 2,
    parameter int unsigned     PC_W         = 32,
    parameter int unsigned     CNT_W        = 32,
    parameter logic [PC_W-1:0] END_PC       = PC_W'(32'h0000_7000),
    parameter int unsigned     HALT_REPEAT  = 4,
    parameter int unsigned     TIMEOUT      = 100000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             cpu_reset,
    input  logic [PC_W-1:0]  pc_f,
    input  logic             stall,
    input  logic             wb_en,
    input  logic [31:0]      wb_pc,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic             timed_out,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Terminal counts, folded to register width once.
    localparam logic [31:0]      HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      SAME_LAST = 32'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN     = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [31:0]      hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
    logic [31:0]      same_cnt_q, same_cnt_d;
    logic             halted_q, halted_d;
    logic             timed_out_q, timed_out_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             done_q, done_d;

    logic pc_same;
    logic halt_hit;
    logic to_hit;

    assign pc_same  = (pc_f == prev_pc_q);
    // A stall freezes the stuck-PC detector, so a stalled repeat never halts.
    assign halt_hit = (pc_f >= END_PC) ||
                      (!stall && pc_same && (same_cnt_q == SAME_LAST));
    assign to_hit   = TO_EN && (cycle_cnt_q == TO_LAST);

    // State and counter registers; reset returns everything to idle/HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            prev_pc_q    <= '0;
            same_cnt_q   <= '0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            prev_pc_q    <= prev_pc_d;
            same_cnt_q   <= same_cnt_d;
            halted_q     <= halted_d;
            timed_out_q  <= timed_out_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
        end
    end

    // Next-state, counter updates and registered output values.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        prev_pc_d    = prev_pc_q;
        same_cnt_d   = same_cnt_q;
        halted_d     = halted_q;
        timed_out_d  = timed_out_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    cpu_reset_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                // Writes to $0 still retire an instruction.
                if (wb_en && (retire_cnt_q != '1)) begin
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                end
                prev_pc_d = pc_f;
                if (!stall) begin
                    same_cnt_d = pc_same ? (same_cnt_q + 32'd1) : '0;
                end
                // Halt takes priority over a timeout on the same edge.
                if (halt_hit) begin
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                    done_d   = 1'b1;
                end else if (to_hit) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            ST_DONE: begin
                // Everything frozen until reset; the core keeps running.
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign state      = state_q;
    assign cpu_reset  = cpu_reset_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign halted     = halted_q;
    assign timed_out  = timed_out_q;
    assign done       = done_q;

`ifdef RUN_CTRL_TRACE_EN
    // Writeback trace in the reference-simulator format, plus the final verdict.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_RUN)) begin
            if (wb_en && (wb_addr != 5'd0)) begin
                $display("%d@%h: $%d <= %h", $time, wb_pc, wb_addr, wb_data);
            end
            if (state_d == ST_DONE) begin
                $display("run_ctrl: cycles=%0d retired=%0d reason=%s",
                         cycle_cnt_d, retire_cnt_d, halted_d ? "halt" : "timeout");
            end
        end
    end
`else
    // Trace-only inputs are intentionally left unobserved in this build.
    logic unused_trace;
    assign unused_trace = ^{wb_pc, wb_addr, wb_data};
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model of the run controller.
module tb_mips_run_ctrl;

    localparam int unsigned RC  = 3;
    localparam int unsigned HR  = 4;
    localparam int unsigned TO  = 50;
    localparam logic [31:0] END = 32'h0000_7000;

    logic        clk;
    logic        reset;
    logic        cpu_reset;
    logic [31:0] pc_f;
    logic        stall;
    logic        wb_en;
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic        halted;
    logic        timed_out;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;

    mips_run_ctrl #(
        .RESET_CYCLES(RC),
        .PC_W        (32),
        .CNT_W       (32),
        .END_PC      (END),
        .HALT_REPEAT (HR),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_reset (cpu_reset),
        .pc_f      (pc_f),
        .stall     (stall),
        .wb_en     (wb_en),
        .wb_pc     (wb_pc),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .state     (state),
        .cycle_cnt (cycle_cnt),
        .retire_cnt(retire_cnt),
        .halted    (halted),
        .timed_out (timed_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // phase: 0 holding the core in reset, 1 running, 2 finished
    int          m_phase;
    int          m_hold_left;   // cpu_reset cycles still owed after reset drops
    longint      m_cyc;
    longint      m_ret;
    logic [31:0] m_last_pc;     // last pc seen while running
    int          m_repeats;     // unchanged-pc observations in a row, stalls ignored
    bit          m_halt;
    bit          m_to;

    task automatic model_step();
        bit end_hit, stuck_hit, limit_hit;
        if (reset) begin
            m_phase = 0; m_hold_left = RC; m_cyc = 0; m_ret = 0;
            m_last_pc = 0; m_repeats = 0; m_halt = 0; m_to = 0;
        end else if (m_phase == 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = 1;
        end else if (m_phase == 1) begin
            end_hit   = (pc_f >= END);
            stuck_hit = !stall && (pc_f == m_last_pc) && (m_repeats + 1 == HR);
            limit_hit = (TO != 0) && (m_cyc + 1 == TO);
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (wb_en && m_ret < 64'hFFFF_FFFF) m_ret++;
            if (!stall) m_repeats = (pc_f == m_last_pc) ? m_repeats + 1 : 0;
            m_last_pc = pc_f;
            if (end_hit || stuck_hit) begin
                m_phase = 2; m_halt = 1;
            end else if (limit_hit) begin
                m_phase = 2; m_to = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_all();
        chk("state",      state,      m_phase);
        chk("cpu_reset",  cpu_reset,  (m_phase == 0));
        chk("cycle_cnt",  cycle_cnt,  m_cyc);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("halted",     halted,     m_halt);
        chk("timed_out",  timed_out,  m_to);
        chk("done",       done,       (m_phase == 2));
    endtask

    // One clock: model consumes the applied inputs, DUT sees the edge, compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset for one cycle and return the number of cpu_reset cycles that follow.
    task automatic enter_run(output int hold_len);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold_len = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cpu_reset) break;
            hold_len++;
            tick();
        end
    endtask

    initial begin : stim
        int n;
        int hl;
        reset = 1'b1; pc_f = 32'h0; stall = 1'b0; wb_en = 1'b0;
        wb_pc = 32'h0; wb_addr = 5'd0; wb_data = 32'h0;

        // 1: reset two cycles, then exactly RC cpu_reset cycles before RUN
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        hl = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cpu_reset) break;
            hl++;
            tick();
        end
        chk("hold_len", hl, 3);
        chk("run_entry_state", state, 1);
        chk("run_entry_cyc", cycle_cnt, 0);

        // 2: PC walks up to END_PC -> halt, then everything freezes
        pc_f = 32'h0000_6FC0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            tick();
            n++;
            pc_f = pc_f + 32'd4;
        end
        chk("endpc_edges", n, 17);
        chk("endpc_halted", halted, 1);
        chk("endpc_timed_out", timed_out, 0);
        for (int i = 0; i < 5; i++) begin
            wb_en = 1'b1; pc_f = 32'h3000;
            tick();
        end
        wb_en = 1'b0;
        chk("freeze_cyc", cycle_cnt, 17);
        chk("freeze_ret", retire_cnt, 0);
        chk("freeze_state", state, 2);

        // 3a: PC stuck, no stall -> halt on the 4th repeat
        enter_run(hl);
        pc_f = 32'h0000_3010;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            tick();
            n++;
        end
        chk("stuck_edges", n, 5);
        chk("stuck_halted", halted, 1);

        // 3b: same with two stall cycles -> halt two cycles later
        enter_run(hl);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            stall = (n == 2 || n == 3);
            tick();
            n++;
        end
        stall = 1'b0;
        chk("stuck_stall_edges", n, 7);
        chk("stuck_stall_cyc", cycle_cnt, 7);

        // 4a: incrementing PC below END_PC -> timeout after TO cycles
        enter_run(hl);
        pc_f = 32'h0000_3000;
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
            pc_f = pc_f + 32'd4;
        end
        chk("to_cyc", cycle_cnt, 50);
        chk("to_timed_out", timed_out, 1);
        chk("to_halted", halted, 0);

        // 4b: END_PC reached on the very timeout edge -> halt wins
        enter_run(hl);
        pc_f = 32'h0000_6F3C;
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
            pc_f = pc_f + 32'd4;
        end
        chk("tie_cyc", cycle_cnt, 50);
        chk("tie_halted", halted, 1);
        chk("tie_timed_out", timed_out, 0);

        // 5: reset mid-RUN at cycle_cnt=20
        enter_run(hl);
        pc_f = 32'h0000_3000;
        for (int i = 0; i < 30; i++) begin
            if (cycle_cnt == 32'd20) break;
            tick();
            pc_f = pc_f + 32'd4;
        end
        chk("mid_pre_cyc", cycle_cnt, 20);
        reset = 1'b1;
        tick();
        chk("mid_rst_state", state, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_cyc", cycle_cnt, 0);
        reset = 1'b0;
        hl = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cpu_reset) break;
            hl++;
            tick();
        end
        chk("mid_hold_len", hl, 3);

        // 6: seven writebacks, two of them to $0
        begin
            logic [4:0] addrs [7] = '{5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 5'd4, 5'd5};
            pc_f = 32'h0000_3000;
            for (int i = 0; i < 7; i++) begin
                wb_en = 1'b1; wb_addr = addrs[i]; wb_pc = pc_f; wb_data = 32'(i + 5);
                tick();
                pc_f = pc_f + 32'd4;
                wb_en = 1'b0;
                tick();
                pc_f = pc_f + 32'd4;
            end
            chk("retire_7", retire_cnt, 7);
        end

        // Randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            enter_run(hl);
            pc_f = 32'h0000_3000;
            for (int i = 0; i < 70; i++) begin
                int sel;
                reset   = ($urandom_range(0, 49) == 0);
                stall   = ($urandom_range(0, 3) == 0);
                wb_en   = $urandom_range(0, 1) == 1;
                wb_addr = 5'($urandom_range(0, 31));
                wb_pc   = pc_f;
                wb_data = $urandom;
                sel = $urandom_range(0, 19);
                if (sel < 9)       pc_f = pc_f;
                else if (sel < 18) pc_f = pc_f + 32'd4;
                else if (sel == 18) pc_f = END + 32'($urandom_range(0, 15) * 4);
                else               pc_f = 32'h3000 + 32'($urandom_range(0, 63) * 4);
                tick();
            end
            reset = 1'b0; stall = 1'b0; wb_en = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
